// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage; registers EXE bus, shapes load data, forwards to decode.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 111,
  parameter int MS_TO_WS_BUS_WD = 70,
  parameter int MS_TO_DS_BUS_WD = 38
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
  input  logic [31:0]                data_sram_rdata
);
  logic                       ms_valid;
  logic                       ms_ready_go;
  logic                       rdata_fresh;
  logic [31:0]                rdata_buf;
  logic [ES_TO_MS_BUS_WD-1:0] bus_r;
  logic [31:0]                rt, res, pc, m, sh, b_ext, h_ext, lwl, lwr, ld, final_result;
  logic [1:0]                 a;
  logic [5:0]                 t;
  logic                       mem_re, gr_we;
  logic [4:0]                 dest;
  logic [15:0]                h;

  assign {rt, a, t, mem_re, gr_we, dest, res, pc} = bus_r;
  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  // SRAM data is only live in the first cycle; after that the captured copy is used
  assign m     = rdata_fresh ? data_sram_rdata : rdata_buf;
  assign sh    = m >> {a, 3'b000};
  assign h     = a[1] ? m[31:16] : m[15:0];
  assign b_ext = {{24{~t[5] & sh[7]}}, sh[7:0]};
  assign h_ext = {{16{~t[5] & h[15]}}, h};

  always_comb begin
    lwl = a == 2'd0 ? {m[7:0], rt[23:0]} :
          a == 2'd1 ? {m[15:0], rt[15:0]} :
          a == 2'd2 ? {m[23:0], rt[7:0]} : m;
    lwr = a == 2'd0 ? m :
          a == 2'd1 ? {rt[31:24], m[31:8]} :
          a == 2'd2 ? {rt[31:16], m[31:16]} : {rt[31:8], m[31:24]};
    ld  = t[1] ? b_ext : t[2] ? h_ext : t[3] ? lwl : t[4] ? lwr : t[0] ? m : 32'h0;
    final_result = mem_re ? ld : res;
  end

  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
  assign ms_to_ds_bus = (ms_valid && gr_we) ? {1'b1, dest, final_result} : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid    <= 1'b0;
      rdata_fresh <= 1'b0;
      rdata_buf   <= 32'h0;
      bus_r       <= '0;
    end else begin
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      if (es_to_ms_valid && ms_allowin) bus_r <= es_to_ms_bus;
      rdata_fresh <= es_to_ms_valid && ms_allowin;
      if (rdata_fresh) rdata_buf <= data_sram_rdata;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors with hand-computed results for mem_stage.
`timescale 1ns/1ps
module tb_mem_stage;
  logic         clk = 1'b0;
  logic         resetn;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [110:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [69:0]  ms_to_ws_bus;
  logic [37:0]  ms_to_ds_bus;
  logic [31:0]  data_sram_rdata;
  int           n_tests = 0;
  int           n_fail  = 0;

  mem_stage dut (
    .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ms_to_ds_bus(ms_to_ds_bus), .data_sram_rdata(data_sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [110:0] mk(input logic [31:0] rt, input logic [1:0] a,
      input logic [5:0] t, input logic re, input logic we, input logic [4:0] dest,
      input logic [31:0] res, input logic [31:0] pc);
    return {rt, a, t, re, we, dest, res, pc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [5:0] t, input logic [1:0] a,
      input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] exp);
    step();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(rt, a, t, 1'b1, 1'b1, 5'd3, 32'h0, 32'h100);
    step();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = rd;
    #2 chk(tag, ms_to_ws_bus[63:32], exp);
  endtask

  initial begin
    resetn = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0; data_sram_rdata = 32'h0;
    #12;
    chk("rst_valid", ms_to_ws_valid, 0);
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_ds", ms_to_ds_bus, 0);
    chk("rst_ws", ms_to_ws_bus, 0);
    resetn = 1'b1;

    do_load("lb",  6'b000010, 2'd3, 32'h0, 32'h80123456, 32'hFFFFFF80);
    do_load("lbu", 6'b100010, 2'd3, 32'h0, 32'h80123456, 32'h00000080);
    do_load("lh",  6'b000100, 2'd2, 32'h0, 32'h9ABC1234, 32'hFFFF9ABC);
    do_load("lhu", 6'b100100, 2'd2, 32'h0, 32'h9ABC1234, 32'h00009ABC);
    do_load("lwl", 6'b001000, 2'd1, 32'hAABBCCDD, 32'h11223344, 32'h3344CCDD);
    do_load("lwr", 6'b010000, 2'd1, 32'hAABBCCDD, 32'h11223344, 32'hAA112233);
    do_load("lb0", 6'b000010, 2'd0, 32'h0, 32'h80123456, 32'h00000056);

    // bubble after the load drains
    step();
    chk("bubble_valid", ms_to_ws_valid, 0);
    chk("bubble_ds", ms_to_ds_bus, 0);

    // back-to-back loads: leave and enter in the same edge
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h0, 2'd0, 6'b000001, 1'b1, 1'b1, 5'd7, 32'h0, 32'h200);
    step();
    es_to_ms_bus    = mk(32'h0, 2'd1, 6'b000010, 1'b1, 1'b1, 5'd8, 32'h0, 32'h204);
    data_sram_rdata = 32'hCAFEF00D;
    #2 chk("b2b_a", ms_to_ws_bus[63:32], 32'hCAFEF00D);
    step();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'h0000A500;
    #2 chk("b2b_b", ms_to_ws_bus, {1'b1, 5'd8, 32'hFFFFFFA5, 32'h204});
    step();

    // LW stalled by WB: value must survive SRAM data changing
    ws_allowin = 1'b0; es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'h0, 2'd0, 6'b000001, 1'b1, 1'b1, 5'd9, 32'h0, 32'h300);
    step();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'hDEADBEEF;
    step();
    data_sram_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #2 chk("stall_ws", ms_to_ws_bus[63:32], 32'hDEADBEEF);
      chk("stall_ds", ms_to_ds_bus, {1'b1, 5'd9, 32'hDEADBEEF});
      chk("stall_allowin", ms_allowin, 0);
      step();
    end
    ws_allowin = 1'b1;
    #2 chk("release_valid", ms_to_ws_valid, 1);
    step();
    chk("release_drain", ms_to_ws_valid, 0);

    // ALU passthrough ignores SRAM data
    es_to_ms_valid = 1'b1; data_sram_rdata = 32'hFFFFFFFF;
    es_to_ms_bus = mk(32'h0, 2'd0, 6'b000000, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h400);
    step();
    es_to_ms_bus = mk(32'h0, 2'd0, 6'b000000, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h404);
    #2 chk("alu_ds", ms_to_ds_bus, {1'b1, 5'd5, 32'h1234});
    chk("alu_ws", ms_to_ws_bus, {1'b1, 5'd5, 32'h1234, 32'h400});
    step();
    es_to_ms_valid = 1'b0;
    #2 chk("alu_nowe_ds", ms_to_ds_bus, 0);
    chk("alu_nowe_valid", ms_to_ws_valid, 1);
    step();

    // async reset in the middle of a stall
    ws_allowin = 1'b0; es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'h0, 2'd0, 6'b000001, 1'b1, 1'b1, 5'd4, 32'h0, 32'h500);
    step();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'h12345678;
    step();
    #2 resetn = 1'b0;
    #1 chk("areset_valid", ms_to_ws_valid, 0);
    chk("areset_allowin", ms_allowin, 1);
    chk("areset_ds", ms_to_ds_bus, 0);
    #3 resetn = 1'b1;
    ws_allowin = 1'b1;
    do_load("post_rst_lw", 6'b000001, 2'd0, 32'h0, 32'h55AA55AA, 32'h55AA55AA);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
